id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register for the 5-stage pipelined CPU. It sits directly downstream of the register file and captures that file's `rdata_A`/`rdata_B` read values together with the decoded control fields. It resolves RAW hazards by forwarding from the EX, MEM and WB stages, and inserts a one-cycle bubble on a load-use hazard. Its registered outputs drive the ALU and the rest of the EX stage.

## Interface
Parameters
- `DW`, 32: datapath width.
- `AW`, 5: register address width.

Ports
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  branch/jump taken; kill the instruction in ID.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  AW  source addresses (same values drive regfile `raddr_A`/`raddr_B`).
- `id_uses_rt`  in  1  instruction reads `rt` as an operand.
- `id_waddr`  in  AW  destination register.
- `id_we`, `id_mem_read`, `id_mem_write`  in  1  decoded controls.
- `id_alu_op`  in  4  ALU operation.
- `id_imm`  in  DW  sign/zero-extended immediate.
- `rdata_A`, `rdata_B`  in  DW  regfile read data.
- `ex_result`  in  DW  ALU result of the instruction currently in EX (combinational).
- `mem_we`, `mem_waddr`, `mem_data`  in  1/AW/DW  MEM-stage producer (load data already resolved).
- `wb_we`, `wb_waddr`, `wb_data`  in  1/AW/DW  WB-stage producer.
- `stall`  out  1  hold PC and IF/ID this cycle (combinational).
- `ex_valid`, `ex_we`, `ex_mem_read`, `ex_mem_write`  out  1  registered controls.
- `ex_rs`, `ex_rt`, `ex_waddr`  out  AW  registered addresses.
- `ex_alu_op`  out  4; `ex_imm`, `ex_opA`, `ex_opB`  out  DW  registered operands.

## Operation
- Load-use hazard:
  - `lu = id_valid & ex_valid & ex_mem_read & ex_we & (ex_waddr != 0) & ((ex_waddr == id_rs) | (id_uses_rt & ex_waddr == id_rt))`.
  - `stall = lu & ~flush`.
- Capture cases on each posedge:
  - `rst`: every output register is cleared to 0.
  - `flush` (priority over `lu`): load a bubble.
  - `lu`: load a bubble; the ID instruction is re-presented next cycle.
  - Otherwise: load the ID fields, with `ex_valid = id_valid`.
- A bubble sets `ex_valid`, `ex_we`, `ex_mem_read` and `ex_mem_write` to 0. The other fields are don't-care and are held at 0.
- Operand forwarding, evaluated independently for A (`id_rs`/`rdata_A`) and B (`id_rt`/`rdata_B`). First match wins:
  1. EX: `ex_valid & ex_we & ~ex_mem_read & ex_waddr == addr` → `ex_result`.
  2. MEM: `mem_we & mem_waddr == addr` → `mem_data`.
  3. WB: `wb_we & wb_waddr == addr` → `wb_data` (see Configuration).
  4. Otherwise → regfile data.
- Address 0 never matches a forwarding source; the operand is the regfile value, which is always 0.
- `ex_opB` always carries the rt operand. Immediate selection happens in EX using `ex_imm`.
- No arithmetic is performed. All fields are passed through at full width.

## Timing
- Latency is 1 cycle: ID fields sampled at edge N appear on the `ex_*` outputs after edge N.
- `stall` is combinational from the current `ex_*` state and ID inputs, valid within the same cycle.
- A load-use stall lasts exactly one cycle: the bubble it inserts clears `ex_mem_read`, so `lu` drops on the next cycle.
  - On the retry the load is in MEM and the operand comes from `mem_data`.
- Reset asserted mid-stall: the next edge clears all state and `stall` returns to 0.
- `flush` and `lu` in the same cycle: bubble inserted, `stall = 0`.

## Configuration
- `WB_BYPASS_EN` defined: WB forwarding source (priority 3) is present.
- `WB_BYPASS_EN` undefined: the WB source is removed and the `wb_*` inputs are ignored.
  - This relies on the regfile's negedge write making `wb_data` visible on `rdata_A`/`rdata_B` before the posedge capture.
  - Result values are identical in both builds when paired with that regfile.

## Test plan
- Reset: drive `rst=1` with all inputs nonzero for one edge → every `ex_*` output is 0 and `stall=0`.
- EX forward: `add r3` in EX with `ex_result=0x55`, ID reads `rs=3` → `ex_opA=0x55` next cycle, `stall=0`.
- Load-use: `lw r4` in EX, ID `rt=4`, `id_uses_rt=1` → `stall=1` for one cycle and a bubble is inserted. Next cycle `mem_data=0xDEAD` → `ex_opB=0xDEAD`, `stall=0`.
- Priority and r0:
  - EX and MEM both write r5 (`0x11` vs `0x22`) → `ex_opA=0x11`.
  - All sources write r0 with `0xFF` and ID reads r0 → `ex_opA=0`.
- Flush vs stall: load-use condition plus `flush=1` → `stall=0`, next `ex_valid=0`, `ex_we=0`.
- WB path: only `wb_we=1`, `wb_waddr=7`, `wb_data=0x1234`, ID reads r7 → `ex_opA=0x1234` in both builds (regfile-backed without `WB_BYPASS_EN`).

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM(/WB when WB_BYPASS_EN is defined) operand forwarding.
// One-cycle latency; load-use hazard raises a combinational stall and inserts a bubble.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic [AW-1:0] id_waddr,
  input  logic          id_we,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic [3:0]    id_alu_op,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] rdata_A,
  input  logic [DW-1:0] rdata_B,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic          ex_we,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] ex_waddr,
  output logic [3:0]    ex_alu_op,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_opA,
  output logic [DW-1:0] ex_opB
);

  logic          r_valid, r_we, r_mem_read, r_mem_write;
  logic [AW-1:0] r_rs, r_rt, r_waddr;
  logic [3:0]    r_alu_op;
  logic [DW-1:0] r_imm, r_opA, r_opB;

  logic          w_lu;
  logic          w_ex_fwd;
  logic [DW-1:0] w_opA, w_opB;

  assign w_lu = id_valid & r_valid & r_mem_read & r_we & (r_waddr != '0) &
                ((r_waddr == id_rs) | (id_uses_rt & (r_waddr == id_rt)));
  assign stall = w_lu & ~flush;

  // A load in EX has no result yet; its consumer waits for the MEM path.
  assign w_ex_fwd = r_valid & r_we & ~r_mem_read;

  always_comb begin
    w_opA = rdata_A;
    if (id_rs != '0) begin
      if (w_ex_fwd && (r_waddr == id_rs))      w_opA = ex_result;
      else if (mem_we && (mem_waddr == id_rs)) w_opA = mem_data;
`ifdef WB_BYPASS_EN
      else if (wb_we && (wb_waddr == id_rs))   w_opA = wb_data;
`endif
    end
  end

  always_comb begin
    w_opB = rdata_B;
    if (id_rt != '0) begin
      if (w_ex_fwd && (r_waddr == id_rt))      w_opB = ex_result;
      else if (mem_we && (mem_waddr == id_rt)) w_opB = mem_data;
`ifdef WB_BYPASS_EN
      else if (wb_we && (wb_waddr == id_rt))   w_opB = wb_data;
`endif
    end
  end

`ifndef WB_BYPASS_EN
  logic w_wb_unused;
  assign w_wb_unused = ^{wb_we, wb_waddr, wb_data};
`endif

  always_ff @(posedge clk) begin
    if (rst || flush || w_lu) begin
      r_valid     <= 1'b0;
      r_we        <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_waddr     <= '0;
      r_alu_op    <= '0;
      r_imm       <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
    end else begin
      r_valid     <= id_valid;
      r_we        <= id_we;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_waddr     <= id_waddr;
      r_alu_op    <= id_alu_op;
      r_imm       <= id_imm;
      r_opA       <= w_opA;
      r_opB       <= w_opB;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_we        = r_we;
  assign ex_mem_read  = r_mem_read;
  assign ex_mem_write = r_mem_write;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_waddr     = r_waddr;
  assign ex_alu_op    = r_alu_op;
  assign ex_imm       = r_imm;
  assign ex_opA       = r_opA;
  assign ex_opB       = r_opB;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with a per-cycle behavioural model.
module tb_id_ex_stage;

  logic        clk, rst, flush;
  logic        id_valid, id_uses_rt, id_we, id_mem_read, id_mem_write;
  logic [4:0]  id_rs, id_rt, id_waddr;
  logic [3:0]  id_alu_op;
  logic [31:0] id_imm, rdata_A, rdata_B, ex_result;
  logic        mem_we, wb_we;
  logic [4:0]  mem_waddr, wb_waddr;
  logic [31:0] mem_data, wb_data;
  logic        stall, ex_valid, ex_we, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rs, ex_rt, ex_waddr;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_imm, ex_opA, ex_opB;

  id_ex_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_waddr(id_waddr), .id_we(id_we), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_op(id_alu_op), .id_imm(id_imm),
    .rdata_A(rdata_A), .rdata_B(rdata_B), .ex_result(ex_result),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_data(mem_data),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_we(ex_we), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_waddr(ex_waddr),
    .ex_alu_op(ex_alu_op), .ex_imm(ex_imm), .ex_opA(ex_opA), .ex_opB(ex_opB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, we, mr, mw;
    logic [4:0]  rs, rt, waddr;
    logic [3:0]  alu;
    logic [31:0] imm, opA, opB;
  } ex_t;

  ex_t m, nxt;
  bit  m_known = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Producers in priority order; the first one writing the address supplies it.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    logic        en [3];
    logic [4:0]  wa [3];
    logic [31:0] d  [3];
    en[0] = m.valid && m.we && !m.mr; wa[0] = m.waddr;   d[0] = ex_result;
    en[1] = mem_we;                   wa[1] = mem_waddr; d[1] = mem_data;
`ifdef WB_BYPASS_EN
    en[2] = wb_we;
`else
    en[2] = 1'b0;
`endif
    wa[2] = wb_waddr; d[2] = wb_data;
    if (a == 5'd0) return rf;
    for (int i = 0; i < 3; i++)
      if (en[i] && wa[i] == a) return d[i];
    return rf;
  endfunction

  function automatic logic model_lu();
    logic dep;
    dep = (m.waddr == id_rs) || (id_uses_rt && m.waddr == id_rt);
    return id_valid && m.valid && m.mr && m.we && (m.waddr != 5'd0) && dep;
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    n = '{valid: 1'b0, we: 1'b0, mr: 1'b0, mw: 1'b0, rs: 5'd0, rt: 5'd0,
          waddr: 5'd0, alu: 4'd0, imm: 32'd0, opA: 32'd0, opB: 32'd0};
    if (rst || flush || model_lu()) return n;
    n.valid = id_valid; n.we = id_we; n.mr = id_mem_read; n.mw = id_mem_write;
    n.rs = id_rs; n.rt = id_rt; n.waddr = id_waddr; n.alu = id_alu_op; n.imm = id_imm;
    n.opA = fwd(id_rs, rdata_A);
    n.opB = fwd(id_rt, rdata_B);
    return n;
  endfunction

  task automatic cycle();
    #1;
    nxt = model_next();
    if (m_known) chk("stall", {31'd0, stall}, {31'd0, model_lu() && !flush});
    @(posedge clk);
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, nxt.valid});
    chk("ex_we", {31'd0, ex_we}, {31'd0, nxt.we});
    chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, nxt.mr});
    chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, nxt.mw});
    chk("ex_rs", {27'd0, ex_rs}, {27'd0, nxt.rs});
    chk("ex_rt", {27'd0, ex_rt}, {27'd0, nxt.rt});
    chk("ex_waddr", {27'd0, ex_waddr}, {27'd0, nxt.waddr});
    chk("ex_alu_op", {28'd0, ex_alu_op}, {28'd0, nxt.alu});
    chk("ex_imm", ex_imm, nxt.imm);
    chk("ex_opA", ex_opA, nxt.opA);
    chk("ex_opB", ex_opB, nxt.opB);
    m = nxt;
    m_known = 1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_waddr = 0; id_we = 0; id_mem_read = 0; id_mem_write = 0; id_alu_op = 0;
    id_imm = 0; rdata_A = 0; rdata_B = 0; ex_result = 0;
    mem_we = 0; mem_waddr = 0; mem_data = 0; wb_we = 0; wb_waddr = 0; wb_data = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] wa, input logic we, input logic mr,
                       input logic mw, input logic [3:0] alu, input logic [31:0] imm);
    idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_waddr = wa;
    id_we = we; id_mem_read = mr; id_mem_write = mw; id_alu_op = alu; id_imm = imm;
    rdata_A = (rs == 0) ? 32'd0 : {27'h0A0A0A0, rs};
    rdata_B = (rt == 0) ? 32'd0 : {27'h0B0B0B0, rt};
  endtask

  initial begin
    idle();
    m = '{valid: 1'b0, we: 1'b0, mr: 1'b0, mw: 1'b0, rs: 5'd0, rt: 5'd0,
          waddr: 5'd0, alu: 4'd0, imm: 32'd0, opA: 32'd0, opB: 32'd0};

    // Reset with every input nonzero
    instr(5'd9, 5'd10, 1, 5'd11, 1, 1, 1, 4'hF, 32'hFFFF_FFFF);
    rst = 1; flush = 1; ex_result = 32'h1; mem_we = 1; mem_waddr = 5'd9;
    mem_data = 32'h2; wb_we = 1; wb_waddr = 5'd10; wb_data = 32'h3;
    cycle();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_opA", ex_opA, 32'd0);
    idle(); #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    cycle();

    // EX forward: add r3, then consumer of r3
    instr(5'd1, 5'd2, 1, 5'd3, 1, 0, 0, 4'h1, 32'h10);
    cycle();
    instr(5'd3, 5'd0, 0, 5'd6, 1, 0, 0, 4'h2, 32'h20);
    ex_result = 32'h55;
    cycle();
    chk("exfwd_opA", ex_opA, 32'h55);

    // Load-use: lw r4, then consumer of rt=4
    instr(5'd1, 5'd0, 0, 5'd4, 1, 1, 0, 4'h0, 32'h4);
    cycle();
    instr(5'd2, 5'd4, 1, 5'd7, 1, 0, 0, 4'h3, 32'h0);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    cycle();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    instr(5'd2, 5'd4, 1, 5'd7, 1, 0, 0, 4'h3, 32'h0);
    mem_we = 1; mem_waddr = 5'd4; mem_data = 32'hDEAD;
    #1;
    chk("lu_retry_stall", {31'd0, stall}, 32'd0);
    cycle();
    chk("lu_retry_opB", ex_opB, 32'hDEAD);

    // Priority: EX beats MEM on r5
    instr(5'd1, 5'd2, 1, 5'd5, 1, 0, 0, 4'h4, 32'h0);
    cycle();
    instr(5'd5, 5'd5, 1, 5'd8, 1, 0, 0, 4'h5, 32'h0);
    ex_result = 32'h11; mem_we = 1; mem_waddr = 5'd5; mem_data = 32'h22;
    cycle();
    chk("prio_opA", ex_opA, 32'h11);
    chk("prio_opB", ex_opB, 32'h11);

    // r0 never forwards
    instr(5'd1, 5'd2, 1, 5'd0, 1, 0, 0, 4'h6, 32'h0);
    cycle();
    instr(5'd0, 5'd0, 1, 5'd9, 1, 0, 0, 4'h7, 32'h0);
    ex_result = 32'hFF; mem_we = 1; mem_waddr = 0; mem_data = 32'hFF;
    wb_we = 1; wb_waddr = 0; wb_data = 32'hFF;
    cycle();
    chk("r0_opA", ex_opA, 32'd0);

    // MEM forward on B while A reads regfile
    instr(5'd12, 5'd13, 1, 5'd14, 1, 0, 1, 4'h8, 32'hCAFE);
    mem_we = 1; mem_waddr = 5'd13; mem_data = 32'hBEEF;
    cycle();
    chk("memfwd_opB", ex_opB, 32'hBEEF);
    chk("mw_pass", {31'd0, ex_mem_write}, 32'd1);

    // Flush together with a load-use condition
    instr(5'd1, 5'd0, 0, 5'd6, 1, 1, 0, 4'h0, 32'h0);
    cycle();
    instr(5'd6, 5'd0, 0, 5'd7, 1, 0, 0, 4'h1, 32'h0);
    flush = 1;
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    cycle();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_we", {31'd0, ex_we}, 32'd0);

    // WB path: regfile already holds wb_data unless bypass is built in
    instr(5'd7, 5'd0, 0, 5'd1, 1, 0, 0, 4'h2, 32'h0);
    wb_we = 1; wb_waddr = 5'd7; wb_data = 32'h1234;
`ifdef WB_BYPASS_EN
    rdata_A = 32'h0BAD;
`else
    rdata_A = 32'h1234;
`endif
    cycle();
    chk("wb_opA", ex_opA, 32'h1234);

    // Load not consumed by uses_rt=0 instruction: no stall
    instr(5'd1, 5'd0, 0, 5'd10, 1, 1, 0, 4'h0, 32'h0);
    cycle();
    instr(5'd2, 5'd10, 0, 5'd11, 1, 0, 0, 4'h1, 32'h0);
    #1;
    chk("no_urt_stall", {31'd0, stall}, 32'd0);
    cycle();

    // Reset asserted mid-stall
    instr(5'd1, 5'd0, 0, 5'd8, 1, 1, 0, 4'h0, 32'h0);
    cycle();
    instr(5'd8, 5'd0, 0, 5'd9, 1, 0, 0, 4'h1, 32'h0);
    rst = 1;
    cycle();
    idle();
    instr(5'd8, 5'd0, 0, 5'd9, 1, 0, 0, 4'h1, 32'h0);
    #1;
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    cycle();

    idle();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
